// File: rtl/csa_sched_pkg.sv
// Shared definitions for the carry-save accumulator job scheduler.
//   state_t    : scheduler FSM states
//   calc_id_w  : requester-ID width, never less than one bit
package csa_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FEED      = 3'd1,
    ISSUE     = 3'd2,
    GAP       = 3'd3,
    WAIT_RDY  = 3'd4,
    TERM      = 3'd5,
    WAIT_DONE = 3'd6,
    RESP      = 3'd7
  } state_t;

  function automatic int calc_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   iReq     : request vector, one bit per requester
//   iPtr     : highest-priority index this round (must be < N_REQ)
//   oGrantId : first requester at or after iPtr, wrapping in index order
//   oAny     : at least one request present (oGrantId meaningless otherwise)
module rr_arbiter
  import csa_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = calc_id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] iReq,
  input  logic [ID_W-1:0]  iPtr,
  output logic [ID_W-1:0]  oGrantId,
  output logic             oAny
);

  always_comb begin
    oAny     = |iReq;
    oGrantId = '0;
    // Walk offsets from farthest to nearest so the nearest valid request
    // (smallest offset from the pointer) is the one left standing.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = i + int'(iPtr);
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (iReq[idx]) oGrantId = ID_W'(idx);
    end
  end

endmodule

// File: rtl/csa_job_scheduler.sv
// Shares one carry_save_accumulator among N_REQ requesters. Each job (a
// stream of operands ending with a last-flagged one) is granted whole, in
// round-robin order, driven through the accumulator's pulse/ready/terminate/
// done handshake, and returned tagged with requester ID and operand count.
//   iReqValid/iReqLast/iReqData/oReqReady : per-requester operand streams
//   oAccA/oAccAccumulate/oAccTerminate    : accumulator command side
//   iAccReady/iAccDone/iAccRes            : accumulator status side
//   oResValid/iResReady/oResData/oResId/oResCount : result handshake
//   oBusy : high whenever the scheduler is not idle
// All outputs come straight from registers.
module csa_job_scheduler
  import csa_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int INPUT_LENGTH  = 16,
  parameter int OUTPUT_LENGTH = 32,
  parameter int CNT_W         = 16,
  localparam int ID_W         = calc_id_w(N_REQ)
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic [N_REQ-1:0]              iReqValid,
  input  logic [N_REQ-1:0]              iReqLast,
  input  logic [N_REQ*INPUT_LENGTH-1:0] iReqData,
  output logic [N_REQ-1:0]              oReqReady,
  output logic [INPUT_LENGTH-1:0]       oAccA,
  output logic                          oAccAccumulate,
  output logic                          oAccTerminate,
  input  logic                          iAccReady,
  input  logic                          iAccDone,
  input  logic [OUTPUT_LENGTH-1:0]      iAccRes,
  output logic                          oResValid,
  input  logic                          iResReady,
  output logic [OUTPUT_LENGTH-1:0]      oResData,
  output logic [ID_W-1:0]               oResId,
  output logic [CNT_W-1:0]              oResCount,
  output logic                          oBusy
);

  state_t                   state_q, state_d;
  logic [ID_W-1:0]          grant_q, grant_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;
  logic [N_REQ-1:0]         req_ready_q, req_ready_d;
  logic [INPUT_LENGTH-1:0]  acc_a_q, acc_a_d;
  logic                     acc_pulse_q, acc_pulse_d;
  logic                     term_q, term_d;
  logic                     busy_q, busy_d;
  logic                     res_valid_q, res_valid_d;
  logic [OUTPUT_LENGTH-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]          res_id_q, res_id_d;
  logic [CNT_W-1:0]         res_cnt_q, res_cnt_d;

  logic [ID_W-1:0]          arb_id;
  logic                     arb_any;
  logic [INPUT_LENGTH-1:0]  req_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_data[gi] = iReqData[gi*INPUT_LENGTH +: INPUT_LENGTH];
  end

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .iReq     (iReqValid),
    .iPtr     (ptr_q),
    .oGrantId (arb_id),
    .oAny     (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    done_d      = done_q;
    acc_a_d     = acc_a_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_cnt_d   = res_cnt_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_id;
          cnt_d   = '0;
          state_d = FEED;
        end
      end
      FEED: begin
        // Only the granted requester is ever offered ready, so a stalled
        // source simply parks the whole scheduler here.
        if (iReqValid[grant_q] && req_ready_q[grant_q]) begin
          acc_a_d = req_data[grant_q];
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          last_d  = iReqLast[grant_q];
          state_d = ISSUE;
        end
      end
      ISSUE:    state_d = GAP;
      // The accumulator's ready may still reflect the previous operand for a
      // cycle after the pulse, so it is not looked at until WAIT_RDY.
      GAP:      state_d = WAIT_RDY;
      WAIT_RDY: begin
        if (iAccReady) state_d = last_q ? TERM : FEED;
      end
      TERM: begin
        done_d  = iAccDone;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // Edge-detect done: a level left over from the previous job must not
        // be mistaken for completion of this one.
        done_d = iAccDone;
        if (iAccDone && !done_q) begin
          res_data_d  = iAccRes;
          res_id_d    = grant_q;
          res_cnt_d   = cnt_q;
          res_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (iResReady) begin
          res_valid_d = 1'b0;
          ptr_d       = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Per-state outputs are derived from the next state so that the
    // registered copies line up exactly with the state they belong to.
    req_ready_d = (state_d == FEED) ? (N_REQ'(1) << grant_d) : '0;
    acc_pulse_d = (state_d == ISSUE);
    term_d      = (state_d == TERM);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= '0;
      acc_a_q     <= '0;
      acc_pulse_q <= 1'b0;
      term_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
      acc_a_q     <= acc_a_d;
      acc_pulse_q <= acc_pulse_d;
      term_q      <= term_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign oReqReady      = req_ready_q;
  assign oAccA          = acc_a_q;
  assign oAccAccumulate = acc_pulse_q;
  assign oAccTerminate  = term_q;
  assign oResValid      = res_valid_q;
  assign oResData       = res_data_q;
  assign oResId         = res_id_q;
  assign oResCount      = res_cnt_q;
  assign oBusy          = busy_q;

endmodule

// File: tb/tb_csa_job_scheduler.sv
module tb_csa_job_scheduler;
  localparam int N   = 4;
  localparam int IL  = 16;
  localparam int OL  = 32;
  localparam int CW  = 16;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_last  = '0;
  logic [N*IL-1:0] req_data  = '0;
  logic [N-1:0]    oReqReady;
  logic [IL-1:0]   oAccA;
  logic            oAccAccumulate, oAccTerminate;
  logic            acc_ready, acc_done;
  logic [OL-1:0]   acc_res;
  logic            oResValid;
  logic            res_ready = 1'b0;
  logic [OL-1:0]   oResData;
  logic [IDW-1:0]  oResId;
  logic [CW-1:0]   oResCount;
  logic            oBusy;

  always #5 clk = ~clk;

  csa_job_scheduler #(
    .N_REQ(N), .INPUT_LENGTH(IL), .OUTPUT_LENGTH(OL), .CNT_W(CW)
  ) dut (
    .iClk(clk), .iRst(rst),
    .iReqValid(req_valid), .iReqLast(req_last), .iReqData(req_data),
    .oReqReady(oReqReady),
    .oAccA(oAccA), .oAccAccumulate(oAccAccumulate), .oAccTerminate(oAccTerminate),
    .iAccReady(acc_ready), .iAccDone(acc_done), .iAccRes(acc_res),
    .oResValid(oResValid), .iResReady(res_ready),
    .oResData(oResData), .oResId(oResId), .oResCount(oResCount),
    .oBusy(oBusy)
  );

  // ---------------- accumulator behavioural model ----------------
  // ready drops on every accumulate pulse and returns after acc_dly cycles;
  // done from the previous job stays high until one cycle after terminate,
  // then rises again acc_dly cycles later with the finished sum.
  int            acc_dly = 1;
  logic [OL-1:0] m_sum;
  int            m_rcnt, m_dcnt, m_tstate;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sum <= '0; acc_ready <= 1'b1; acc_done <= 1'b0; acc_res <= '0;
      m_rcnt <= 0; m_dcnt <= 0; m_tstate <= 0;
    end else begin
      if (oAccAccumulate) begin
        m_sum <= m_sum + {16'h0, oAccA};
        acc_ready <= 1'b0;
        m_rcnt <= acc_dly;
      end else if (!acc_ready) begin
        if (m_rcnt == 0) acc_ready <= 1'b1;
        else m_rcnt <= m_rcnt - 1;
      end
      case (m_tstate)
        0: if (oAccTerminate) m_tstate <= 1;
        1: begin acc_done <= 1'b0; m_dcnt <= acc_dly; m_tstate <= 2; end
        default: begin
          if (m_dcnt == 0) begin
            acc_done <= 1'b1; acc_res <= m_sum; m_sum <= '0; m_tstate <= 0;
          end else m_dcnt <= m_dcnt - 1;
        end
      endcase
    end
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: got %s", name, what);
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [OL-1:0]  sum;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];

  task automatic expect_res(input int id, input logic [OL-1:0] sum, input int cnt);
    exp_t e;
    e.id = IDW'(id); e.sum = sum; e.cnt = CW'(cnt);
    sb.push_back(e);
  endtask

  // ---------------- result monitor / protocol watchers ----------------
  int             acc_pulses = 0;
  int             term_pulses = 0;
  int             bp_left = 0;
  logic           prev_acc = 1'b0, prev_term = 1'b0, seen = 1'b0;
  logic [OL-1:0]  h_data;
  logic [IDW-1:0] h_id;
  logic [CW-1:0]  h_cnt;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_acc = 1'b0; prev_term = 1'b0; seen = 1'b0; res_ready = 1'b0;
    end else begin
      if (oAccAccumulate) begin
        acc_pulses++;
        if (prev_acc) fail("acc_pulse_width", "pulse longer than 1 cycle");
      end
      if (oAccTerminate) begin
        term_pulses++;
        if (prev_term) fail("term_pulse_width", "pulse longer than 1 cycle");
      end
      prev_acc  = oAccAccumulate;
      prev_term = oAccTerminate;
      if (!$onehot0(oReqReady)) fail("ready_onehot0", $sformatf("oReqReady=%b", oReqReady));
      if (oResValid) begin
        if (seen) begin
          check("hold_data", oResData, h_data);
          check("hold_id", oResId, h_id);
          check("hold_count", oResCount, h_cnt);
        end else begin
          seen = 1'b1; h_data = oResData; h_id = oResId; h_cnt = oResCount;
        end
        if (bp_left > 0) begin
          bp_left--;
          res_ready = 1'b0;
          check("bp_no_grant", oReqReady, 0);
        end else begin
          res_ready = 1'b1;
          $display("result id=%0d data=%h count=%0d", oResId, oResData, oResCount);
          if (sb.size() == 0) begin
            fail("unexpected_result", $sformatf("id=%0d data=%h", oResId, oResData));
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("res_id", oResId, e.id);
            check("res_data", oResData, e.sum);
            check("res_count", oResCount, e.cnt);
          end
          seen = 1'b0;
        end
      end else begin
        seen = 1'b0;
        res_ready = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_job(input int r, input int nops, input logic [255:0] ops,
                           input bit set_last, input int stall_at, input int stall_len);
    int guard;
    @(negedge clk);
    for (int i = 0; i < nops; i++) begin
      if (i == stall_at) begin
        req_valid[r] = 1'b0;
        repeat (stall_len) @(negedge clk);
      end
      req_valid[r] = 1'b1;
      req_last[r]  = set_last && (i == nops - 1);
      req_data[r*IL +: IL] = ops[i*IL +: IL];
      guard = 0;
      while (!oReqReady[r] && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 3000) begin
        fail("feed_timeout", $sformatf("no ready for req%0d op%0d", r, i));
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        return;
      end
      @(negedge clk);  // handshake took place at the posedge just passed
    end
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int g = 0;
    while ((sb.size() != 0 || oResValid) && g < budget) begin
      @(negedge clk);
      g++;
    end
    if (g >= budget) fail("drain_timeout", $sformatf("%0d results pending", sb.size()));
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [255:0] ops3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [255:0] v;
    v = '0; v[15:0] = a; v[31:16] = b; v[47:32] = c;
    return v;
  endfunction

  function automatic logic [127:0] all_outs();
    return {oReqReady, oAccA, oAccAccumulate, oAccTerminate, oResValid,
            oResData, oResId, oResCount, oBusy};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check("reset_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int           req;
    int           nops;
    logic [255:0] ops;
    logic [OL-1:0] sum;
    int           dly;
  } job_t;

  job_t jobs[4];

  initial begin
    logic [15:0] pat [4];
    int a0, t0;

    pat = '{16'h0701, 16'h00F1, 16'h10B7, 16'hA2C1};
    jobs[0].req = 0; jobs[0].nops = 16; jobs[0].ops = '0;
    for (int k = 0; k < 16; k++) jobs[0].ops[k*16 +: 16] = pat[k % 4];
    jobs[0].sum = 32'h0002EDA8; jobs[0].dly = 1;
    jobs[1].req = 3; jobs[1].nops = 1;
    jobs[1].ops = ops3(16'hFFFF, 16'h0, 16'h0); jobs[1].sum = 32'h0000FFFF; jobs[1].dly = 0;
    jobs[2].req = 2; jobs[2].nops = 3;
    jobs[2].ops = ops3(16'h1234, 16'h4321, 16'h8000); jobs[2].sum = 32'h0000D555; jobs[2].dly = 2;
    jobs[3].req = 1; jobs[3].nops = 3;
    jobs[3].ops = ops3(16'hFFFF, 16'hFFFF, 16'hFFFF); jobs[3].sum = 32'h0002FFFD; jobs[3].dly = 3;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", oBusy, 0);

    // table-driven single jobs: sum, id, count, and exact pulse counts
    for (int j = 0; j < 4; j++) begin
      acc_dly = jobs[j].dly;
      a0 = acc_pulses; t0 = term_pulses;
      expect_res(jobs[j].req, jobs[j].sum, jobs[j].nops);
      drive_job(jobs[j].req, jobs[j].nops, jobs[j].ops, 1'b1, -1, 0);
      wait_drain(2000);
      check($sformatf("acc_pulses_job%0d", j), acc_pulses - a0, jobs[j].nops);
      check($sformatf("term_pulses_job%0d", j), term_pulses - t0, 1);
    end

    // arbitration from reset: 0, 2, 3 all waiting
    acc_dly = 1;
    do_reset();
    expect_res(0, 32'h11, 1);
    expect_res(2, 32'h22, 1);
    expect_res(3, 32'h33, 1);
    fork
      drive_job(0, 1, ops3(16'h0011, 16'h0, 16'h0), 1'b1, -1, 0);
      drive_job(2, 1, ops3(16'h0022, 16'h0, 16'h0), 1'b1, -1, 0);
      drive_job(3, 1, ops3(16'h0033, 16'h0, 16'h0), 1'b1, -1, 0);
    join
    wait_drain(2000);
    // pointer wrapped past 3, so 0 beats 3
    expect_res(0, 32'h44, 1);
    expect_res(3, 32'h55, 1);
    fork
      drive_job(0, 1, ops3(16'h0044, 16'h0, 16'h0), 1'b1, -1, 0);
      drive_job(3, 1, ops3(16'h0055, 16'h0, 16'h0), 1'b1, -1, 0);
    join
    wait_drain(2000);

    // result backpressure with another requester waiting
    acc_dly = 2;
    bp_left = 10;
    expect_res(0, 32'h300, 2);
    expect_res(1, 32'h7, 1);
    fork
      drive_job(0, 2, ops3(16'h0100, 16'h0200, 16'h0), 1'b1, -1, 0);
      begin
        repeat (3) @(negedge clk);
        drive_job(1, 1, ops3(16'h0007, 16'h0, 16'h0), 1'b1, -1, 0);
      end
    join
    wait_drain(2000);
    check("bp_consumed", bp_left, 0);

    // source stall: req1 idles 5 cycles mid-job while req2 is waiting
    acc_dly = 1;
    expect_res(1, 32'h6666, 3);
    expect_res(2, 32'h5, 1);
    fork
      drive_job(1, 3, ops3(16'h1111, 16'h2222, 16'h3333), 1'b1, 1, 5);
      begin
        repeat (3) @(negedge clk);
        drive_job(2, 1, ops3(16'h0005, 16'h0, 16'h0), 1'b1, -1, 0);
      end
    join
    wait_drain(2000);

    // reset while waiting for the accumulator after the 3rd operand
    acc_dly = 6;
    drive_job(1, 3, ops3(16'h0100, 16'h0100, 16'h0100), 1'b0, -1, 0);
    repeat (2) @(negedge clk);  // ISSUE -> GAP -> WAIT_RDY
    check("busy_before_reset", oBusy, 1);
    rst = 1'b1;
    #1 check("reset_mid_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    acc_dly = 1;
    repeat (20) @(negedge clk);
    check("no_result_after_abort", oResValid, 0);
    expect_res(1, 32'h3, 2);
    drive_job(1, 2, ops3(16'h0001, 16'h0002, 16'h0), 1'b1, -1, 0);
    wait_drain(2000);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    bad++;
    $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
